// File: rtl/pipelined_n_bit_adder.sv
// Pipelined N-bit add/subtract. The carry chain is cut into SEG-bit segments with one register
// stage per segment, and a single advance enable lets the pipeline run at one operation per clock.
module pipelined_n_bit_adder #(
  parameter int N   = 16,
  parameter int SEG = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         Cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] y,
  output logic         Cout,
  output logic         ovf
);

  localparam int STAGES = N / SEG;

  logic [N-1:0] r_a [STAGES];
  logic [N-1:0] r_b [STAGES];
  logic [N-1:0] r_y [STAGES];
  logic         r_c [STAGES];
  logic         r_v [STAGES];
  logic         r_ovf;

  logic w_adv;
  logic w_accept;
  logic w_unused_ops;

  assign w_adv    = ~r_v[STAGES-1] | out_ready;
  assign in_ready = w_adv & ~rst;
  assign w_accept = in_valid & in_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic [N-1:0] w_a_in;
    logic [N-1:0] w_b_in;
    logic [N-1:0] w_y_in;
    logic [N-1:0] w_y_nxt;
    logic         w_c_in;
    logic         w_v_in;
    logic [SEG:0] w_sum;

    // Stage 0 takes the effective operands: B and the carry are inverted for subtract.
    if (s == 0) begin : g_head
      assign w_a_in = a;
      assign w_b_in = sub ? ~b : b;
      assign w_c_in = sub ? ~Cin : Cin;
      assign w_y_in = {N{1'b0}};
      assign w_v_in = w_accept;
    end else begin : g_body
      assign w_a_in = r_a[s-1];
      assign w_b_in = r_b[s-1];
      assign w_c_in = r_c[s-1];
      assign w_y_in = r_y[s-1];
      assign w_v_in = r_v[s-1];
    end

    assign w_sum = {1'b0, w_a_in[s*SEG +: SEG]} + {1'b0, w_b_in[s*SEG +: SEG]}
                 + {{SEG{1'b0}}, w_c_in};

    always_comb begin
      w_y_nxt                = w_y_in;
      w_y_nxt[s*SEG +: SEG]  = w_sum[SEG-1:0];
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_v[s] <= 1'b0;
        r_c[s] <= 1'b0;
        r_a[s] <= {N{1'b0}};
        r_b[s] <= {N{1'b0}};
        r_y[s] <= {N{1'b0}};
      end else if (w_adv) begin
        r_v[s] <= w_v_in;
        r_c[s] <= w_sum[SEG];
        r_a[s] <= w_a_in;
        r_b[s] <= w_b_in;
        r_y[s] <= w_y_nxt;
      end
    end

    // Carry into the MSB is recovered from the MSB sum bit; overflow is it XOR the carry out.
    if (s == STAGES - 1) begin : g_tail
      always_ff @(posedge clk) begin
        if (rst) begin
          r_ovf <= 1'b0;
        end else if (w_adv) begin
          r_ovf <= w_a_in[N-1] ^ w_b_in[N-1] ^ w_sum[SEG-1] ^ w_sum[SEG];
        end
      end
    end
  end

  assign w_unused_ops = ^{r_a[STAGES-1], r_b[STAGES-1]};

  assign out_valid = r_v[STAGES-1];
  assign y         = r_y[STAGES-1];
  assign Cout      = r_c[STAGES-1];
  assign ovf       = r_ovf;

endmodule

// File: doc/pipelined_n_bit_adder.md
Name: pipelined_n_bit_adder

Overview:
- Parametrised, pipelined successor to the combinational N-bit adder.
- Splits the N-bit carry chain into SEG-bit segments, one register stage per segment, so wide adds close timing at high clock rates.
- Adds a subtract mode, a signed-overflow flag and a valid/ready handshake.
- Sits in arithmetic datapaths wherever a wide add/subtract must sustain one operation per clock.

Parameters:
- N, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, segment width in bits; 1 <= SEG <= N.
- STAGES, N/SEG, derived (localparam): pipeline depth and latency in cycles.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand set on a, b, Cin, sub is valid.
- in_ready  output  1  block accepts the operand set this cycle.
- a  input  N  operand A.
- b  input  N  operand B.
- Cin  input  1  carry-in for add; borrow-in for subtract.
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  y, Cout, ovf hold a valid result.
- out_ready  input  1  downstream accepts the result this cycle.
- y  output  N  sum or difference.
- Cout  output  1  carry-out for add; NOT-borrow for subtract.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - add: {Cout,y} = a + b + Cin.
  - sub: {Cout,y} = a + ~b + ~Cin, i.e. y = a - b - Cin; Cout = 1 means no borrow.
  - ovf = carry into MSB XOR carry out of MSB, computed on the effective (possibly inverted) B operand.
  - All arithmetic is modulo 2^N; no saturation.
- Pipeline:
  - Stage s (0..STAGES-1) adds bits [s*SEG +: SEG] using the carry registered by stage s-1; stage 0 uses the effective carry-in.
  - Each stage registers its result slice, its carry, the already-computed lower slices, the not-yet-used upper operand slices, and a valid bit.
  - ovf is produced in the last stage.
- Handshake:
  - Global advance enable: adv = !out_valid | out_ready.
  - in_ready = adv & !rst.
  - An operand set is accepted on a rising edge where in_valid & in_ready.
  - On adv, every stage shifts forward one position. Stage-0 valid is loaded with (in_valid & in_ready); empty slots travel as bubbles.
  - When adv = 0, all stages hold their contents, and out_valid, y, Cout and ovf stay stable.
  - A result is consumed on an edge where out_valid & out_ready.
- Latency and throughput:
  - A set accepted at edge k produces out_valid = 1 after edge k+STAGES-1 (registered output; visible STAGES cycles later) when there is no stall.
  - Throughput is one result per cycle while out_ready = 1.
  - Results leave in acceptance order; no loss, no duplication.
- Simultaneous accept and consume in the same cycle is legal at full rate.
- STAGES = 1 degenerates to a single registered adder with latency 1.
- Reset:
  - On a rising edge with rst = 1, all valid bits clear; y = 0, Cout = 0, ovf = 0, out_valid = 0.
  - Data registers inside the pipeline also clear.
  - In-flight operations are discarded and nothing emerges after reset.
  - Inputs presented while rst = 1 are ignored.
- in_valid may drop without a transfer. Operand values are sampled only on accept.

Test Plan (N=16, SEG=4, STAGES=4 unless stated):
1. Basic add: reset; 0x1234 + 0x1111, Cin=0, sub=0 -> after 4 cycles out_valid=1, y=0x2345, Cout=0, ovf=0.
2. Full carry ripple: 0xFFFF + 0x0001, Cin=0 -> y=0x0000, Cout=1, ovf=0. Also 0xFFFF + 0x0000, Cin=1 -> same result.
3. Subtract and overflow:
   - 0x0005 - 0x0007, sub=1 -> y=0xFFFE, Cout=0, ovf=0.
   - 0x7FFF + 0x0001 -> y=0x8000, ovf=1.
   - 0x8000 - 0x0001, sub=1 -> y=0x7FFF, Cout=1, ovf=1.
4. Stream with backpressure:
   - 8 random sets back-to-back; out_ready held 0 for 3 cycles mid-stream.
   - Required: in_ready=0 during the stall, outputs frozen, all 8 results correct, in order, none duplicated.
5. Reset mid-operation: 3 sets in flight, assert rst for 1 cycle -> out_valid=0 from the next cycle; no stale result ever appears; the next set after reset completes normally.
6. Configuration sweep: N=8, SEG=8 (latency 1) and N=32, SEG=8 (latency 4); 0xFF+0x01 and 0xFFFFFFFF+0x1 -> y=0, Cout=1 at the specified latency.
